// File: rtl/fifo_word_serializer.sv
// Serializes words from a first-word-fall-through FIFO into OUT_WIDTH-bit valid/ready slices.
// The next word loads on the same edge that accepts the last slice, so back-to-back words have no gap.
module fifo_word_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_done
);

  localparam int unsigned RATIO     = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  if (((DATA_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_ratio
    $error("fifo_word_serializer: DATA_WIDTH must be an integral multiple (>= 2x) of OUT_WIDTH");
  end

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic [IDX_WIDTH-1:0]  sel_idx;
  int unsigned           sel_base;
  logic                  accept;
  logic                  load;

  assign out_valid  = (state_q == SEND);
  assign busy       = out_valid;
  assign out_last   = out_valid & (idx_q == LAST_IDX);
  assign accept     = out_valid & out_ready;
  assign load       = ~fifo_empty & ((state_q == IDLE) | (accept & out_last));
  // Gate with reset so a non-empty FIFO is never popped while the block is held in reset.
  assign fifo_rd_en = load & reset_n;
  assign words_done = words_q;

  always_comb begin
    sel_idx  = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
    sel_base = 32'(sel_idx) * OUT_WIDTH;
    out_data = '0;
    if (out_valid) begin
      out_data = hold_q[sel_base +: OUT_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    words_d = words_q;
    if (accept && out_last) begin
      words_d = words_q + CNT_WIDTH'(1);
    end
    if (load) begin
      state_d = SEND;
      hold_d  = fifo_rd_data;
      idx_d   = '0;
    end else if (accept) begin
      if (out_last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      words_q <= words_d;
    end
  end

endmodule
